// File: rtl/ysyx_23060303_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060303_seq_ctrl
// Purpose  : Multi-cycle instruction sequencer for the ysyx_23060303 NPC core.
//            Walks each instruction through FETCH -> WAIT -> EXEC -> WB.
//            Stops on ebreak or on a fetch watchdog timeout. Maintains
//            cycle and retired-instruction counters.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            if_req_*            - instruction fetch request handshake
//            if_rsp_* / inst     - fetch response and latched instruction
//            ex_start / ex_done  - EXU start pulse and completion
//            rd_en_dec / rf_wen  - decoded and issued register write enable
//            pc_wen              - PC advance enable
//            halt / fetch_err    - sticky stop flag and its timeout cause
//            cycle_cnt / instret_cnt - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060303_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             if_req_valid,
  input  logic             if_req_ready,
  input  logic             if_rsp_valid,
  output logic             if_rsp_ready,
  input  logic [31:0]      if_rsp_inst,
  output logic [31:0]      inst,
  output logic             ex_start,
  input  logic             ex_done,
  input  logic             rd_en_dec,
  output logic             rf_wen,
  output logic             pc_wen,
  output logic             halt,
  output logic             fetch_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [31:0]     c_ebreak  = 32'h0010_0073;
  localparam int unsigned     c_wd_w    = 10;
  localparam logic [c_wd_w-1:0] c_timeout = c_wd_w'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_ex_first;
  logic              r_fetch_err;
  logic [c_wd_w-1:0] r_wdog;
  logic [31:0]       r_inst;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_instret;

  logic [c_wd_w-1:0] w_wdog_inc;
  logic              w_wdog_expire;

  // The watchdog spans FETCH and WAIT together; it is only cleared when a
  // new fetch begins, so a slow request eats into the response budget.
  assign w_wdog_inc    = r_wdog + c_wd_w'(1);
  assign w_wdog_expire = (w_wdog_inc == c_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_ex_first  <= 1'b0;
      r_fetch_err <= 1'b0;
      r_wdog      <= '0;
      r_inst      <= '0;
      r_cycle     <= '0;
      r_instret   <= '0;
    end else begin
      if (r_state != S_HALT) begin
        r_cycle <= r_cycle + CNT_W'(1);
      end
      r_ex_first <= 1'b0;

      case (r_state)
        S_FETCH: begin
          // A completing handshake takes priority over an expiring watchdog.
          if (if_req_ready) begin
            r_state <= S_WAIT;
          end else if (w_wdog_expire) begin
            r_state     <= S_HALT;
            r_fetch_err <= 1'b1;
          end else begin
            r_wdog <= w_wdog_inc;
          end
        end

        S_WAIT: begin
          if (if_rsp_valid) begin
            r_inst <= if_rsp_inst;
            if (if_rsp_inst == c_ebreak) begin
              // ebreak retires here; it never reaches the EXU or write-back.
              r_state   <= S_HALT;
              r_instret <= r_instret + CNT_W'(1);
            end else begin
              r_state    <= S_EXEC;
              r_ex_first <= 1'b1;
            end
          end else if (w_wdog_expire) begin
            r_state     <= S_HALT;
            r_fetch_err <= 1'b1;
          end else begin
            r_wdog <= w_wdog_inc;
          end
        end

        S_EXEC: begin
          if (ex_done) begin
            r_state <= S_WB;
          end
        end

        S_WB: begin
          r_instret <= r_instret + CNT_W'(1);
          r_wdog    <= '0;
          r_state   <= S_FETCH;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign if_req_valid = (r_state == S_FETCH);
  assign if_rsp_ready = (r_state == S_WAIT);
  assign ex_start     = r_ex_first;
  // The only input-to-output path: the decoder's write enable gated by WB.
  assign rf_wen       = (r_state == S_WB) & rd_en_dec;
  assign pc_wen       = (r_state == S_WB);
  assign halt         = (r_state == S_HALT);
  assign fetch_err    = r_fetch_err;
  assign inst         = r_inst;
  assign cycle_cnt    = r_cycle;
  assign instret_cnt  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060303_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060303_seq_ctrl
// Purpose  : Self-checking bench for ysyx_23060303_seq_ctrl. Each instruction
//            is described by its stall counts; the expected per-cycle output
//            timeline, timeout outcome and counter values are derived from
//            those counts arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060303_seq_ctrl;

  localparam int          TO     = 8;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [31:0] if_rsp_inst, inst;
  logic        ex_start, ex_done, rd_en_dec, rf_wen, pc_wen, halt, fetch_err;
  logic [31:0] cycle_cnt, instret_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_cyc    = '0;
  logic [31:0] m_ret    = '0;

  ysyx_23060303_seq_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .if_rsp_inst(if_rsp_inst), .inst(inst),
    .ex_start(ex_start), .ex_done(ex_done), .rd_en_dec(rd_en_dec),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .fetch_err(fetch_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs {req_v,rsp_r,ex_start,rf_wen,pc_wen,halt,fetch_err}
  // (and optionally inst), then advance to just after the next rising edge.
  task automatic cycle(input logic rq, input logic rv, input logic dn, input logic rd,
                       input logic [31:0] w, input logic [6:0] exp_o,
                       input bit ci, input logic [31:0] exp_inst, input string tag);
    if_req_ready = rq;
    if_rsp_valid = rv;
    ex_done      = dn;
    rd_en_dec    = rd;
    if_rsp_inst  = w;
    #1;
    chk(tag, 32'({if_req_valid, if_rsp_ready, ex_start, rf_wen, pc_wen, halt, fetch_err}),
        32'(exp_o));
    if (ci) chk({tag, "_inst"}, inst, exp_inst);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    if_req_ready = 1'($urandom);
    if_rsp_valid = 1'($urandom);
    ex_done      = 1'($urandom);
    rd_en_dec    = 1'($urandom);
    if_rsp_inst  = $urandom;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cyc = '0;
    m_ret = '0;
    chk("rst_outputs", 32'({if_req_valid, if_rsp_ready, ex_start, rf_wen, pc_wen, halt, fetch_err}),
        32'(7'b1000000));
    chk("rst_inst", inst, 32'h0);
    chk("rst_cycle_cnt", cycle_cnt, 32'h0);
    chk("rst_instret_cnt", instret_cnt, 32'h0);
  endtask

  // Three cycles in HALT: outputs quiet, counters frozen, inst held.
  task automatic halt_cycles(input logic err, input logic [31:0] exp_inst);
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
            {5'b00000, 1'b1, err}, 1'b1, exp_inst, "halt");
      chk("halt_cycle_frozen", cycle_cnt, m_cyc);
      chk("halt_instret", instret_cnt, m_ret);
    end
  endtask

  // dr/dv/dd: cycles of if_req_ready / if_rsp_valid / ex_done held low.
  task automatic run_instr(input int dr, input int dv, input int dd, input logic rd,
                           input logic [31:0] w, output bit halted);
    bit          to_f, to_w, ebk;
    int          nf, nw;
    logic        acc;
    logic [31:0] inst_before;
    ebk  = (w == EBREAK);
    to_f = (dr >= TO);
    to_w = !to_f && (dr + dv >= TO);
    nf   = to_f ? TO : dr + 1;
    nw   = to_w ? TO - dr : dv + 1;
    halted = 1'b0;
    inst_before = inst;
    chk("start_cycle_cnt", cycle_cnt, m_cyc);
    chk("start_instret_cnt", instret_cnt, m_ret);

    for (int i = 0; i < nf; i++) begin
      cycle(!to_f && (i == nf - 1), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
            7'b1000000, 1'b1, inst_before, "fetch");
      m_cyc++;
    end
    if (to_f) begin
      halt_cycles(1'b1, inst_before);
      halted = 1'b1;
      return;
    end

    for (int i = 0; i < nw; i++) begin
      acc = !to_w && (i == nw - 1);
      cycle(1'($urandom), acc, 1'($urandom), 1'($urandom), acc ? w : $urandom,
            7'b0100000, 1'b1, inst_before, "wait");
      m_cyc++;
    end
    if (to_w) begin
      halt_cycles(1'b1, inst_before);
      halted = 1'b1;
      return;
    end
    if (ebk) begin
      m_ret++;
      halt_cycles(1'b0, w);
      halted = 1'b1;
      return;
    end

    for (int i = 0; i <= dd; i++) begin
      cycle(1'($urandom), 1'($urandom), (i == dd), 1'($urandom), $urandom,
            {2'b00, (i == 0), 4'b0000}, 1'b1, w, "exec");
      m_cyc++;
    end
    cycle(1'($urandom), 1'($urandom), 1'($urandom), rd, $urandom,
          {3'b000, rd, 1'b1, 2'b00}, 1'b1, w, "wb");
    m_cyc++;
    m_ret++;
  endtask

  initial begin
    bit          h;
    logic [31:0] c0;
    logic [31:0] w;
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    ex_done      = 1'b0;
    rd_en_dec    = 1'b0;
    if_rsp_inst  = '0;

    // Basic addi, all handshakes immediate.
    do_reset();
    run_instr(0, 0, 0, 1'b1, 32'h0010_0093, h);
    chk("basic_instret", instret_cnt, 32'd1);
    chk("basic_cycle", cycle_cnt, 32'd4);

    // Backpressure: 3 + 2 + 4 extra stall cycles on top of 4.
    c0 = cycle_cnt;
    run_instr(3, 2, 4, 1'b1, 32'h0020_8133, h);
    chk("backpressure_latency", cycle_cnt - c0, 32'd13);

    // ebreak, then reset out of HALT.
    run_instr(0, 1, 0, 1'b1, EBREAK, h);
    chk("ebreak_halted", 32'(h), 32'd1);
    do_reset();

    // Fetch timeout after exactly TO FETCH cycles.
    run_instr(20, 0, 0, 1'b0, 32'h0000_0013, h);
    do_reset();
    // Handshake on the TO-th cycle wins over the watchdog.
    run_instr(TO - 1, 0, 0, 1'b1, 32'h0000_0013, h);
    chk("timeout_boundary_no_halt", 32'(halt), 32'd0);
    // Timeout accumulated across FETCH and WAIT.
    run_instr(5, 5, 0, 1'b1, 32'h0000_0013, h);
    do_reset();

    // Reset during EXEC.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom, 7'b1000000, 1'b0, 32'h0, "r5_fetch");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0050_0113, 7'b0100000, 1'b0, 32'h0, "r5_wait");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 7'b0010000, 1'b1, 32'h0050_0113, "r5_exec");
    do_reset();

    // Write suppression and back-to-back throughput.
    for (int i = 0; i < 100; i++) begin
      run_instr(0, 0, 0, 1'b0, 32'h0000_0013 | (32'(i) << 20), h);
    end
    chk("b2b_instret", instret_cnt, 32'd100);
    chk("b2b_cycle", cycle_cnt, 32'd400);

    // Randomized mix, including occasional ebreak and timeouts.
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom;
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 5)), 1'($urandom), w, h);
      if (h) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060303_seq_ctrl.md
# ysyx_23060303_seq_ctrl

Multi-cycle instruction sequencer for the ysyx_23060303 NPC core. It replaces the free-running fetch/execute timing with a state machine with the following steps:

- Fetch over a valid/ready instruction-memory handshake.
- Hold the fetched instruction stable for the IDU, register file and EXU.
- Start the EXU and wait for it to finish.
- Issue the single-cycle register-file write and PC update.

It detects `ebreak` and stops the core. It also halts on a fetch timeout, and maintains cycle and retired-instruction counters.

## Interface

Parameters:
- `TIMEOUT`, default 255: fetch watchdog limit in cycles, valid range 1..1023.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_req_valid` output 1: fetch request to instruction memory.
- `if_req_ready` input 1: memory accepts the request.
- `if_rsp_valid` input 1: instruction response valid.
- `if_rsp_ready` output 1: sequencer accepts the response.
- `if_rsp_inst` input 32: fetched instruction word.
- `inst` output 32: latched instruction fed to IDU, register file and EXU.
- `ex_start` output 1: one-cycle pulse starting the EXU.
- `ex_done` input 1: EXU result valid.
- `rd_en_dec` input 1: IDU-decoded register write enable for `inst`.
- `rf_wen` output 1: register-file write enable.
- `pc_wen` output 1: PC advance enable to the IFU.
- `halt` output 1: core stopped (sticky).
- `fetch_err` output 1: halt was caused by a fetch timeout.
- `cycle_cnt` output `CNT_W`: cycles since reset while not halted.
- `instret_cnt` output `CNT_W`: retired instructions.

## Operation

States: FETCH, WAIT, EXEC, WB, HALT. Reset enters FETCH.

- **FETCH**
  - `if_req_valid`=1.
  - On `if_req_valid && if_req_ready`, go to WAIT.
- **WAIT**
  - `if_rsp_ready`=1.
  - On `if_rsp_valid`, latch `if_rsp_inst` into `inst`.
  - If the word equals 32'h0010_0073 (`ebreak`), go to HALT and increment `instret_cnt`.
  - Otherwise go to EXEC.
  - A response is accepted only in WAIT. `if_rsp_valid` in any other state is ignored.
- **EXEC**
  - `ex_start`=1 only in the first EXEC cycle.
  - `ex_done` is honoured in any EXEC cycle, including the first. On `ex_done`, go to WB.
- **WB** (exactly one cycle)
  - `rf_wen`=`rd_en_dec`.
  - `pc_wen`=1.
  - `instret_cnt` increments.
  - Go to FETCH.
- **HALT**
  - Absorbing; only `rst` leaves it.
  - `halt`=1. All handshake and enable outputs are 0.

Other rules:
- `inst` changes only on response acceptance in WAIT. It is stable from EXEC through WB.
- Watchdog counter:
  - Cleared on entry to FETCH.
  - Increments every cycle spent in FETCH or WAIT without the completing handshake.
  - When it reaches `TIMEOUT`, go to HALT with `fetch_err`=1.
  - A handshake completing in the same cycle the counter would hit `TIMEOUT` wins; no error is raised.
- No timeout applies in EXEC. The EXU is trusted to finish.
- `cycle_cnt` increments every non-reset cycle while not in HALT. It wraps modulo 2^`CNT_W`.
- `instret_cnt` wraps modulo 2^`CNT_W`.
- All outputs are decoded from registered state. There are no combinational paths from inputs to outputs, except the following:
  - `rf_wen` follows `rd_en_dec` in WB.

## Timing

- Reset values:
  - state=FETCH.
  - `inst`=0.
  - `halt`=0, `fetch_err`=0.
  - Counters=0.
  - Watchdog=0.
- Consequently, in the first cycle after reset deasserts, `if_req_valid`=1 and all other outputs are 0.
- Best-case instruction latency is 4 cycles: FETCH (ready same cycle), WAIT (rsp same cycle), EXEC (done same cycle), WB.
- Each cycle of `if_req_ready`, `if_rsp_valid` or `ex_done` low adds one cycle in the corresponding state.
- `ebreak`:
  - `halt` rises in the cycle after the WAIT acceptance.
  - `ex_start`, `rf_wen` and `pc_wen` are never asserted for it.
- `rst` asserted in any state, including mid-handshake or in HALT, forces the reset values on the next edge. Any in-flight request or response is dropped.

## Test plan

1. **Basic instruction.** Reset, then ready/valid/done all tied 1, fetch `addi` 32'h0010_0093, `rd_en_dec`=1.
   - `if_req_valid` at cycle 0; `inst`=32'h0010_0093 from cycle 2.
   - `ex_start` at cycle 2; `rf_wen`=`pc_wen`=1 at cycle 3.
   - `instret_cnt`=1 at cycle 4.
2. **Backpressure.** `if_req_ready` low 3 cycles, `if_rsp_valid` low 2 cycles, `ex_done` low 4 cycles.
   - Instruction completes in 13 cycles.
   - `ex_start` is a single pulse; `inst` is stable throughout EXEC/WB.
3. **ebreak.** Fetch 32'h0010_0073.
   - `halt`=1 one cycle after acceptance; `instret_cnt` increments.
   - `ex_start`, `rf_wen`, `pc_wen` never pulse.
   - `cycle_cnt` is frozen afterwards.
4. **Fetch timeout.** `TIMEOUT`=8, `if_req_ready` held 0.
   - `halt`=`fetch_err`=1 after exactly 8 FETCH cycles.
   - Variant: with `if_req_ready`=1 on the 8th cycle, WAIT is entered and no error is raised.
5. **Reset mid-operation.** Assert `rst` during EXEC, then separately during HALT.
   - Next cycle: state FETCH, `inst`=0, counters 0, `halt`/`fetch_err`=0.
6. **Write suppression and counters.** `rd_en_dec`=0 and `ex_done` held 1.
   - `rf_wen`=0 while `pc_wen`=1 in WB.
   - 100 back-to-back instructions give `instret_cnt`=100 and `cycle_cnt`=400.
